serial_paralelo: RTL and testbench

SERIAL_PARALELO -- requirements
Module: serial_paralelo

---
 rtl/serial_paralelo_pkg.sv | 23 ++
 rtl/serial_paralelo_if.sv | 39 +++
 rtl/serial_paralelo_detector_coma.sv | 13 +
 rtl/serial_paralelo.sv | 170 +++++++++++++++++
 tb/tb_serial_paralelo.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_paralelo_pkg.sv
// Shared constants, state encoding and helpers for the serial-to-parallel comma aligner.
// Optional statistics counter is enabled with SERIAL_PARALELO_STATS_EN.
package serial_paralelo_pkg;

  localparam int unsigned CANTIDAD_BITS_DEF = 10;

  // K28.5 in both running disparities, MSB first on the line
  localparam logic [9:0] K28_5_RDN = 10'b0011111010;
  localparam logic [9:0] K28_5_RDP = 10'b1100000101;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } sp_state_e;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] inc);
    logic [8:0] s;
    s = {1'b0, a} + {7'd0, inc};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/serial_paralelo_if.sv
// Bus bundle for serial_paralelo: serial input side plus aligned parallel output side.
// cuenta_errores exists only when SERIAL_PARALELO_STATS_EN is defined.
interface serial_paralelo_if
  import serial_paralelo_pkg::*;
#(
  parameter int unsigned CANTIDAD_BITS = CANTIDAD_BITS_DEF
);

  logic                     enb;
  logic                     entrada;
  logic [CANTIDAD_BITS-1:0] salida;
  logic                     valido;
  logic                     bloqueado;
  logic                     coma;
`ifdef SERIAL_PARALELO_STATS_EN
  logic [7:0]               cuenta_errores;

  modport master (
    output enb, entrada,
    input  salida, valido, bloqueado, coma, cuenta_errores
  );

  modport slave (
    input  enb, entrada,
    output salida, valido, bloqueado, coma, cuenta_errores
  );
`else
  modport master (
    output enb, entrada,
    input  salida, valido, bloqueado, coma
  );

  modport slave (
    input  enb, entrada,
    output salida, valido, bloqueado, coma
  );
`endif

endinterface

// File: rtl/serial_paralelo_detector_coma.sv
// Matches the current serial window against both K28.5 disparities.
module detector_coma
  import serial_paralelo_pkg::*;
#(
  parameter int unsigned W = CANTIDAD_BITS_DEF
) (
  input  logic [W-1:0] w,
  output logic         es_coma
);

  assign es_coma = (w == W'(K28_5_RDN)) || (w == W'(K28_5_RDP));

endmodule

// File: rtl/serial_paralelo.sv
// Serial-to-parallel converter with K28.5 comma alignment and lock/loss hysteresis.
// Define SERIAL_PARALELO_STATS_EN to add the saturating cuenta_errores counter.
//
// state     | meaning
// ST_HUNT   | searching for a comma at any bit position
// ST_VERIFY | comma seen, counting consecutive boundary-aligned commas
// ST_LOCKED | aligned; every boundary emits a word, misaligned commas count toward loss
module serial_paralelo
  import serial_paralelo_pkg::*;
#(
  parameter int unsigned CANTIDAD_BITS = CANTIDAD_BITS_DEF,
  parameter int unsigned LOCK_COUNT    = 4,
  parameter int unsigned LOSS_COUNT    = 4
) (
  input  logic               clk,
  input  logic               rst,
  serial_paralelo_if.slave   bus
);

  localparam int unsigned CW = $clog2(CANTIDAD_BITS);
  localparam int unsigned GW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned EW = $clog2(LOSS_COUNT + 1);

  sp_state_e                state_q, state_d;
  logic [CANTIDAD_BITS-2:0] sr_q, sr_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [GW-1:0]            good_q, good_d;
  logic [EW-1:0]            err_q, err_d;
  logic [CANTIDAD_BITS-1:0] salida_q, salida_d;
  logic                     valido_q, valido_d;
  logic                     coma_q, coma_d;
  logic                     bloqueado_q, bloqueado_d;
`ifdef SERIAL_PARALELO_STATS_EN
  logic [7:0]               cuenta_q, cuenta_d;
`endif

  logic [CANTIDAD_BITS-1:0] w;
  logic                     es_coma;
  logic                     at_bnd;
  logic [GW-1:0]            good_inc;
  logic [EW-1:0]            err_inc;

  assign w        = {sr_q, bus.entrada};
  assign at_bnd   = (cnt_q == CW'(CANTIDAD_BITS - 1));
  assign good_inc = (good_q == GW'(LOCK_COUNT)) ? good_q : good_q + GW'(1);
  assign err_inc  = (err_q == EW'(LOSS_COUNT)) ? err_q : err_q + EW'(1);

  detector_coma #(.W(CANTIDAD_BITS)) u_detector_coma (
    .w       (w),
    .es_coma (es_coma)
  );

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    good_d   = good_q;
    err_d    = err_q;
    salida_d = salida_q;
    valido_d = 1'b0;
    coma_d   = 1'b0;
`ifdef SERIAL_PARALELO_STATS_EN
    cuenta_d = cuenta_q;
`endif

    if (bus.enb) begin
      sr_d  = w[CANTIDAD_BITS-2:0];
      cnt_d = at_bnd ? '0 : cnt_q + CW'(1);

      unique case (state_q)
        ST_HUNT: begin
          if (es_coma) begin
            cnt_d   = '0;
            good_d  = GW'(1);
            state_d = ST_VERIFY;
          end
        end

        ST_VERIFY: begin
          if (at_bnd) begin
            if (es_coma) begin
              good_d = good_inc;
              if (good_inc == GW'(LOCK_COUNT)) begin
                state_d = ST_LOCKED;
                err_d   = '0;
              end
            end else begin
              good_d  = '0;
              state_d = ST_HUNT;
            end
          end else if (es_coma) begin
            // comma off the expected grid: restart verification on the new phase
            cnt_d  = '0;
            good_d = GW'(1);
          end
        end

        ST_LOCKED: begin
          if (at_bnd) begin
            salida_d = w;
            valido_d = 1'b1;
            coma_d   = es_coma;
            if (es_coma) err_d = '0;
          end else if (es_coma) begin
            if (err_inc == EW'(LOSS_COUNT)) begin
              state_d = ST_HUNT;
              good_d  = '0;
              err_d   = '0;
`ifdef SERIAL_PARALELO_STATS_EN
              cuenta_d = sat_add8(cuenta_q, 2'd2);
`endif
            end else begin
              err_d = err_inc;
`ifdef SERIAL_PARALELO_STATS_EN
              cuenta_d = sat_add8(cuenta_q, 2'd1);
`endif
            end
          end
        end

        default: begin
          state_d = ST_HUNT;
          good_d  = '0;
          err_d   = '0;
        end
      endcase
    end

    bloqueado_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HUNT;
      sr_q        <= '0;
      cnt_q       <= '0;
      good_q      <= '0;
      err_q       <= '0;
      salida_q    <= '0;
      valido_q    <= 1'b0;
      coma_q      <= 1'b0;
      bloqueado_q <= 1'b0;
`ifdef SERIAL_PARALELO_STATS_EN
      cuenta_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      good_q      <= good_d;
      err_q       <= err_d;
      salida_q    <= salida_d;
      valido_q    <= valido_d;
      coma_q      <= coma_d;
      bloqueado_q <= bloqueado_d;
`ifdef SERIAL_PARALELO_STATS_EN
      cuenta_q    <= cuenta_d;
`endif
    end
  end

  assign bus.salida    = salida_q;
  assign bus.valido    = valido_q;
  assign bus.coma      = coma_q;
  assign bus.bloqueado = bloqueado_q;
`ifdef SERIAL_PARALELO_STATS_EN
  assign bus.cuenta_errores = cuenta_q;
`endif

endmodule

// File: tb/tb_serial_paralelo.sv
// Scoreboard bench for serial_paralelo: bit-stream reference model feeds an expectation
// queue, a negedge monitor checks every cycle. Honours SERIAL_PARALELO_STATS_EN.
`timescale 1ns/1ps
module tb_serial_paralelo;
  import serial_paralelo_pkg::*;

  localparam int N      = 10;
  localparam int LOCK_N = 4;
  localparam int LOSS_N = 4;
  localparam logic [9:0] C_NEG = 10'b0011111010;
  localparam logic [9:0] C_POS = 10'b1100000101;

  localparam int M_SEARCH = 0;
  localparam int M_CONFIRM = 1;
  localparam int M_ALIGNED = 2;

  typedef struct packed {
    logic [9:0] word;
    logic       is_comma;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_paralelo_if #(.CANTIDAD_BITS(N)) bus ();

  serial_paralelo #(
    .CANTIDAD_BITS (N),
    .LOCK_COUNT    (LOCK_N),
    .LOSS_COUNT    (LOSS_N)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks   = 0;
  int   failures = 0;
  bit   mon_on   = 1'b0;

  exp_t exp_q[$];
  exp_t mon_e;
  logic hist[$];
  int   idx, anchor, m_mode, m_good, m_err, m_stats;
  logic exp_lock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] window();
    logic [9:0] v;
    v = '0;
    foreach (hist[i]) v = {v[8:0], hist[i]};
    return v;
  endfunction

  task automatic model_reset();
    hist.delete();
    exp_q.delete();
    idx      = 0;
    anchor   = 0;
    m_mode   = M_SEARCH;
    m_good   = 0;
    m_err    = 0;
    m_stats  = 0;
    exp_lock = 1'b0;
  endtask

  // One accepted bit: decide by bit-position arithmetic relative to the last comma anchor.
  task automatic model_step(input logic en, input logic b);
    logic [9:0] wv;
    bit isc, aligned;
    exp_t e;
    if (en) begin
      hist.push_back(b);
      if (hist.size() > N) void'(hist.pop_front());
      idx++;
      wv      = window();
      isc     = (wv == C_NEG) || (wv == C_POS);
      aligned = ((idx - anchor) % N) == 0;
      case (m_mode)
        M_SEARCH: begin
          if (isc) begin
            anchor = idx; m_good = 1; m_mode = M_CONFIRM;
          end
        end
        M_CONFIRM: begin
          if (aligned) begin
            if (isc) begin
              m_good = (m_good + 1 > LOCK_N) ? LOCK_N : m_good + 1;
              if (m_good >= LOCK_N) begin
                m_mode = M_ALIGNED; m_err = 0;
              end
            end else begin
              m_good = 0; m_mode = M_SEARCH;
            end
          end else if (isc) begin
            anchor = idx; m_good = 1;
          end
        end
        default: begin
          if (aligned) begin
            e.word = wv; e.is_comma = isc;
            exp_q.push_back(e);
            if (isc) m_err = 0;
          end else if (isc) begin
            m_err++;
            m_stats = (m_stats + 1 > 255) ? 255 : m_stats + 1;
            if (m_err >= LOSS_N) begin
              m_mode = M_SEARCH; m_good = 0; m_err = 0;
              m_stats = (m_stats + 1 > 255) ? 255 : m_stats + 1;
            end
          end
        end
      endcase
    end
    exp_lock = (m_mode == M_ALIGNED);
  endtask

  task automatic step(input logic en, input logic b);
    rst         = 1'b0;
    bus.enb     = en;
    bus.entrada = b;
    @(posedge clk);
    #1;
    model_step(en, b);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      rst         = 1'b1;
      bus.entrada = i[0];
      bus.enb     = 1'($urandom);
      @(posedge clk);
      #1;
      model_reset();
    end
    rst = 1'b0;
  endtask

  task automatic send_word(input logic [9:0] wv);
    for (int i = 9; i >= 0; i--) step(1'b1, wv[i]);
  endtask

  // Monitor: one comparison set per cycle, popping expectations as words are due.
  always @(negedge clk) begin
    if (mon_on && !rst) begin
      check("bloqueado", 32'(bus.bloqueado), 32'(exp_lock));
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("valido", 32'(bus.valido), 32'd1);
        check("salida", 32'(bus.salida), 32'(mon_e.word));
        check("coma", 32'(bus.coma), 32'(mon_e.is_comma));
      end else begin
        check("valido_idle", 32'(bus.valido), 32'd0);
        check("coma_idle", 32'(bus.coma), 32'd0);
      end
`ifdef SERIAL_PARALELO_STATS_EN
      check("cuenta_errores", 32'(bus.cuenta_errores), 32'(m_stats));
`endif
    end
  end

  initial begin
    logic [9:0] rw;
    int r;
    bus.enb     = 1'b0;
    bus.entrada = 1'b0;
    model_reset();

    // reset with entrada toggling
    do_reset(3);
    check("rst_salida", 32'(bus.salida), 32'd0);
    check("rst_valido", 32'(bus.valido), 32'd0);
    check("rst_bloqueado", 32'(bus.bloqueado), 32'd0);
    check("rst_coma", 32'(bus.coma), 32'd0);
    mon_on = 1'b1;

    // lock: 3 random bits, 4 commas, then a data word
    for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom));
    for (int k = 0; k < 3; k++) send_word(C_NEG);
    for (int i = 9; i >= 1; i--) step(1'b1, C_NEG[i]);
    check("lock_before_lsb", 32'(bus.bloqueado), 32'd0);
    step(1'b1, C_NEG[0]);
    check("lock_after_4th", 32'(bus.bloqueado), 32'd1);
    send_word(10'b1010101010);
    check("lock_word_valido", 32'(bus.valido), 32'd1);
    check("lock_word_salida", 32'(bus.salida), 32'h2AA);
    check("lock_word_coma", 32'(bus.coma), 32'd0);

    // enable gap of 7 clocks in the middle of a word
    rw = 10'b1100110011;
    for (int i = 9; i >= 6; i--) step(1'b1, rw[i]);
    for (int g = 0; g < 7; g++) step(1'b0, 1'($urandom));
    check("gap_bloqueado", 32'(bus.bloqueado), 32'd1);
    for (int i = 5; i >= 0; i--) step(1'b1, rw[i]);
    check("gap_valido", 32'(bus.valido), 32'd1);
    check("gap_salida", 32'(bus.salida), 32'(rw));

    // loss of lock: four commas each shifted a further 3 bits
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
      send_word(C_NEG);
      if (k == 2) check("loss_still_locked", 32'(bus.bloqueado), 32'd1);
    end
    check("loss_bloqueado", 32'(bus.bloqueado), 32'd0);
`ifdef SERIAL_PARALELO_STATS_EN
    check("loss_cuenta", 32'(bus.cuenta_errores), 32'd5);
`endif

    // verify failure: 2 commas then a non-comma at the boundary
    do_reset(1);
    send_word(C_NEG);
    send_word(C_NEG);
    send_word(10'b0000011111);
    check("vfail_bloqueado", 32'(bus.bloqueado), 32'd0);
    for (int k = 0; k < 3; k++) send_word(C_NEG);
    check("vfail_restart_3", 32'(bus.bloqueado), 32'd0);
    send_word(C_NEG);
    check("vfail_restart_4", 32'(bus.bloqueado), 32'd1);

    // loopback of a constant RD+ comma word
    do_reset(2);
    for (int k = 0; k < 8; k++) send_word(C_POS);
    check("loop_bloqueado", 32'(bus.bloqueado), 32'd1);
    check("loop_salida", 32'(bus.salida), 32'(C_POS));
    check("loop_coma", 32'(bus.coma), 32'd1);

    // randomized traffic: comma-heavy words, bit slips, enable gaps, rare resets
    for (int n = 0; n < 1200; n++) begin
      r = $urandom_range(0, 99);
      if (r < 45)      rw = C_NEG;
      else if (r < 65) rw = C_POS;
      else             rw = 10'($urandom);
      r = $urandom_range(0, 99);
      if (r < 6) begin
        for (int s = 0; s < $urandom_range(1, 9); s++) step(1'b1, 1'($urandom));
      end else if (r == 6) begin
        do_reset(1);
      end
      for (int i = 9; i >= 0; i--) begin
        while ($urandom_range(0, 99) < 12) step(1'b0, 1'($urandom));
        step(1'b1, rw[i]);
      end
    end

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    check("drain_queue", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
